// File: rtl/axi_lite_write_initiator_if.sv
// rtl/axi_lite_write_initiator_if.sv - signal bundle between the write initiator and its neighbours
//
// Purpose: groups the local command port, the AXI-like write channel and the
// status outputs of axi_lite_write_initiator into one interface.
// Modports:
//   master - the initiator's view (drives cmd_ready, aw*, w*, bready, status)
//   slave  - the view of the surrounding logic / responder (drives cmd_*, awready,
//            wready, bvalid, bresp)
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_data/cmd_strb   local single-beat write command
//   axi_awvalid/axi_awaddr/axi_awready               write address channel
//   axi_wvalid/axi_wdata/axi_wstrb/axi_wready        write data channel
//   axi_bvalid/axi_bresp/axi_bready                  write response channel
//   done_valid/done_resp                             one-cycle completion report
//   busy/err_count/timeout_flag                      status

interface axi_lite_write_initiator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [DATA_WIDTH-1:0]     cmd_data;
    logic [DATA_WIDTH/8-1:0]   cmd_strb;

    logic                      axi_awvalid;
    logic [ADDR_WIDTH-1:0]     axi_awaddr;
    logic                      axi_awready;
    logic                      axi_wvalid;
    logic [DATA_WIDTH-1:0]     axi_wdata;
    logic [DATA_WIDTH/8-1:0]   axi_wstrb;
    logic                      axi_wready;
    logic                      axi_bvalid;
    logic [1:0]                axi_bresp;
    logic                      axi_bready;

    logic                      done_valid;
    logic [1:0]                done_resp;
    logic                      busy;
    logic [7:0]                err_count;
    logic                      timeout_flag;

    modport master (
        input  cmd_valid, cmd_addr, cmd_data, cmd_strb,
        output cmd_ready,
        output axi_awvalid, axi_awaddr,
        input  axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb,
        input  axi_wready,
        input  axi_bvalid, axi_bresp,
        output axi_bready,
        output done_valid, done_resp, busy, err_count, timeout_flag
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_data, cmd_strb,
        input  cmd_ready,
        input  axi_awvalid, axi_awaddr,
        output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb,
        output axi_wready,
        output axi_bvalid, axi_bresp,
        input  axi_bready,
        input  done_valid, done_resp, busy, err_count, timeout_flag
    );
endinterface

// File: rtl/axi_lite_write_initiator.sv
// rtl/axi_lite_write_initiator.sv - single-outstanding AXI-like write initiator
//
// Purpose: accepts one local write command at a time, presents it on the write
// address and write data channels (each completing independently), then waits
// for the write response and reports it with a one-cycle done pulse. Keeps a
// saturating error count of non-OKAY responses and a sticky timeout flag that
// is raised when a transaction stays in ISSUE+RESP for TIMEOUT_CYCLES cycles.
// The timeout is only reported; the transaction keeps following the handshakes.
//
// Parameters:
//   DATA_WIDTH      write data width, multiple of 8
//   ADDR_WIDTH      address width
//   TIMEOUT_CYCLES  ISSUE+RESP cycles before timeout_flag sets, 1..65535
// Ports:
//   clk_domain_a    sole clock, rising edge
//   rst             synchronous, active-high reset
//   bus (master)    command, write channel and status signals, see the interface
//
// Timing (all readies high, response immediate): command accepted at edge N,
// AW/W handshake at N+1, B handshake at N+2, done_valid visible after N+2 with
// cmd_ready high in the same cycle, so commands can be taken every 3 cycles.

module axi_lite_write_initiator #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_domain_a,
    input  logic                          rst,
    axi_lite_write_initiator_if.master    bus
);

    localparam int          STRB_WIDTH  = DATA_WIDTH / 8;
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;

    logic                   awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic                   wvalid_q, wvalid_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]  wstrb_q, wstrb_d;
    logic                   bready_q, bready_d;
    logic                   done_valid_q, done_valid_d;
    logic [1:0]             done_resp_q, done_resp_d;
    logic                   busy_q, busy_d;
    logic [7:0]             err_count_q, err_count_d;
    logic                   timeout_flag_q, timeout_flag_d;
    logic [15:0]            tmo_cnt_q, tmo_cnt_d;

    logic                   cmd_ready_w;
    logic                   cmd_fire;
    logic                   aw_fire;
    logic                   w_fire;
    logic                   b_fire;
    logic                   issue_complete;

    // cmd_ready is the only combinational output: low during reset so a command
    // presented while rst is high is never considered accepted.
    assign cmd_ready_w = (state_q == ST_IDLE) && !rst;
    assign cmd_fire    = bus.cmd_valid && cmd_ready_w;
    assign aw_fire     = awvalid_q && bus.axi_awready;
    assign w_fire      = wvalid_q && bus.axi_wready;
    assign b_fire      = bready_q && bus.axi_bvalid;

    // A channel counts as finished once its valid has dropped or is handshaking
    // this cycle; this lets AW and W complete in either order or together.
    assign issue_complete = (!awvalid_q || aw_fire) && (!wvalid_q || w_fire);

    // State register
    always_ff @(posedge clk_domain_a) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_complete) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        wvalid_d     = wvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bready_d     = bready_q;
        done_valid_d = 1'b0;
        done_resp_d  = done_resp_q;
        err_count_d  = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    awaddr_d  = bus.cmd_addr;
                    wdata_d   = bus.cmd_data;
                    wstrb_d   = bus.cmd_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                end
                if (issue_complete) begin
                    bready_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (b_fire) begin
                    bready_d     = 1'b0;
                    done_valid_d = 1'b1;
                    done_resp_d  = bus.axi_bresp;
                    if ((bus.axi_bresp != 2'b00) && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // The timeout counter restarts with every accepted command and counts
        // each cycle spent in ISSUE or RESP, saturating at its maximum.
        tmo_cnt_d = tmo_cnt_q;
        if (cmd_fire) begin
            tmo_cnt_d = 16'd0;
        end else if ((state_q != ST_IDLE) && (tmo_cnt_q != 16'hFFFF)) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end

        timeout_flag_d = timeout_flag_q;
        if ((state_q != ST_IDLE) && (tmo_cnt_d >= TIMEOUT_LIM)) begin
            timeout_flag_d = 1'b1;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk_domain_a) begin
        if (rst) begin
            awvalid_q      <= 1'b0;
            awaddr_q       <= '0;
            wvalid_q       <= 1'b0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            bready_q       <= 1'b0;
            done_valid_q   <= 1'b0;
            done_resp_q    <= 2'b00;
            busy_q         <= 1'b0;
            err_count_q    <= 8'd0;
            timeout_flag_q <= 1'b0;
            tmo_cnt_q      <= 16'd0;
        end else begin
            awvalid_q      <= awvalid_d;
            awaddr_q       <= awaddr_d;
            wvalid_q       <= wvalid_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            bready_q       <= bready_d;
            done_valid_q   <= done_valid_d;
            done_resp_q    <= done_resp_d;
            busy_q         <= busy_d;
            err_count_q    <= err_count_d;
            timeout_flag_q <= timeout_flag_d;
            tmo_cnt_q      <= tmo_cnt_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready_w;
    assign bus.axi_awvalid  = awvalid_q;
    assign bus.axi_awaddr   = awaddr_q;
    assign bus.axi_wvalid   = wvalid_q;
    assign bus.axi_wdata    = wdata_q;
    assign bus.axi_wstrb    = wstrb_q;
    assign bus.axi_bready   = bready_q;
    assign bus.done_valid   = done_valid_q;
    assign bus.done_resp    = done_resp_q;
    assign bus.busy         = busy_q;
    assign bus.err_count    = err_count_q;
    assign bus.timeout_flag = timeout_flag_q;

endmodule
